// File: rtl/game_pkg.sv
// Shared types and helpers for the LED memory game sequencer:
// FSM state encoding, pattern lengths and LED encodings.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_GAP   = 3'd2,
    ST_INPUT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LEN_TC1 = 4'd8;
  localparam logic [3:0] LEN_TC2 = 4'd5;
  localparam logic [3:0] LEN_TC3 = 4'd3;

  function automatic logic [9:0] score_led(input logic [1:0] score);
    logic [9:0] pat;
    case (score)
      2'd0:    pat = 10'h000;
      2'd1:    pat = 10'h200;
      2'd2:    pat = 10'h2AA;
      2'd3:    pat = 10'h3FF;
      default: pat = 10'h000;
    endcase
    return pat;
  endfunction

  // Digits above 9 have no LED and light nothing.
  function automatic logic [9:0] digit_onehot(input logic [3:0] d);
    logic [9:0] pat;
    if (d <= 4'd9) begin
      pat = 10'd1 << d;
    end else begin
      pat = 10'd0;
    end
    return pat;
  endfunction

  function automatic logic [3:0] pattern_len(input logic [1:0] tc);
    logic [3:0] len;
    case (tc)
      2'd1:    len = LEN_TC1;
      2'd2:    len = LEN_TC2;
      2'd3:    len = LEN_TC3;
      default: len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Fixed digit patterns of the memory game, looked up by testcase and position.
// Purely combinational; `last` marks the final digit of a pattern.
module pattern_rom (
  input  logic [1:0] testcase,
  input  logic [2:0] idx,
  output logic [3:0] digit,
  output logic       last
);

  // Pattern table lookup
  always_comb begin
    digit = 4'd0;
    last  = 1'b0;
    case (testcase)
      2'd3: begin
        case (idx)
          3'd0:    digit = 4'd9;
          3'd1:    digit = 4'd2;
          3'd2:    begin digit = 4'd7; last = 1'b1; end
          default: digit = 4'd0;
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    digit = 4'd0;
          3'd1:    digit = 4'd4;
          3'd2:    digit = 4'd1;
          3'd3:    digit = 4'd3;
          3'd4:    begin digit = 4'd2; last = 1'b1; end
          default: digit = 4'd0;
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    digit = 4'd1;
          3'd1:    digit = 4'd9;
          3'd2:    digit = 4'd4;
          3'd3:    digit = 4'd2;
          3'd4:    digit = 4'd0;
          3'd5:    digit = 4'd8;
          3'd6:    digit = 4'd7;
          3'd7:    begin digit = 4'd5; last = 1'b1; end
          default: digit = 4'd0;
        endcase
      end
      default: begin
        digit = 4'd0;
        last  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/memory_game_ctrl.sv
// LED memory game sequencer: replays a pattern on the LED bar, checks the
// player's key entries against it and keeps a saturating round score.
module memory_game_ctrl
  import game_pkg::*;
#(
  parameter int SHOW_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] testcase,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [9:0] led,
  output logic [1:0] score,
  output logic       busy,
  output logic       is_finish,
  output logic       pass,
  output logic       fail
);

  localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_r;
  logic [1:0]    tc_r;
  logic [2:0]    idx_r;
  logic [TW-1:0] timer_r;
  logic [9:0]    led_r;
  logic [1:0]    score_r;
  logic          busy_r;
  logic          is_finish_r;
  logic          pass_r;
  logic          fail_r;

  logic [1:0] rom_tc_s;
  logic [2:0] rom_idx_s;
  logic [3:0] rom_digit_s;
  logic       rom_last_s;
  logic       show_last_s;
  logic       key_ok_s;
  logic [1:0] score_inc_s;

  // ROM address: the incoming testcase at start, the upcoming digit at the end of a gap
  always_comb begin
    if (state_r == ST_IDLE) begin
      rom_tc_s  = testcase;
      rom_idx_s = 3'd0;
    end else if (state_r == ST_GAP) begin
      rom_tc_s  = tc_r;
      rom_idx_s = idx_r + 3'd1;
    end else begin
      rom_tc_s  = tc_r;
      rom_idx_s = idx_r;
    end
  end

  pattern_rom u_rom (
    .testcase (rom_tc_s),
    .idx      (rom_idx_s),
    .digit    (rom_digit_s),
    .last     (rom_last_s)
  );

  assign show_last_s = ({1'b0, idx_r} == (pattern_len(tc_r) - 4'd1));
  assign key_ok_s    = (key_digit <= 4'd9) && (key_digit == rom_digit_s);
  assign score_inc_s = (score_r == 2'd3) ? 2'd3 : (score_r + 2'd1);

  // Round sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      tc_r        <= 2'd0;
      idx_r       <= 3'd0;
      timer_r     <= '0;
      led_r       <= 10'd0;
      score_r     <= 2'd0;
      busy_r      <= 1'b0;
      is_finish_r <= 1'b0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      is_finish_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (testcase != 2'd0)) begin
            tc_r    <= testcase;
            idx_r   <= 3'd0;
            timer_r <= '0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            busy_r  <= 1'b1;
            led_r   <= digit_onehot(rom_digit_s);
            state_r <= ST_SHOW;
          end else begin
            led_r <= (testcase == 2'd0) ? score_led(score_r) : 10'd0;
          end
        end
        ST_SHOW: begin
          if (timer_r == SHOW_LAST) begin
            timer_r <= '0;
            led_r   <= 10'd0;
            state_r <= ST_GAP;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_GAP: begin
          if (timer_r == GAP_LAST) begin
            timer_r <= '0;
            if (show_last_s) begin
              idx_r   <= 3'd0;
              state_r <= ST_INPUT;
            end else begin
              idx_r   <= idx_r + 3'd1;
              led_r   <= digit_onehot(rom_digit_s);
              state_r <= ST_SHOW;
            end
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        // A key on the timeout boundary cycle is still judged as a key
        ST_INPUT: begin
          if (key_valid) begin
            if (key_ok_s) begin
              idx_r   <= idx_r + 3'd1;
              timer_r <= '0;
              if (rom_last_s) begin
                pass_r      <= 1'b1;
                is_finish_r <= 1'b1;
                state_r     <= ST_DONE;
              end
            end else begin
              fail_r      <= 1'b1;
              is_finish_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end else if (timer_r == TO_LAST) begin
            fail_r      <= 1'b1;
            is_finish_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_DONE: begin
          if (pass_r) begin
            score_r <= score_inc_s;
          end
          led_r   <= (testcase == 2'd0) ? score_led(pass_r ? score_inc_s : score_r) : 10'd0;
          idx_r   <= 3'd0;
          timer_r <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          led_r   <= 10'd0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign led       = led_r;
  assign score     = score_r;
  assign busy      = busy_r;
  assign is_finish = is_finish_r;
  assign pass      = pass_r;
  assign fail      = fail_r;

endmodule
